// File: rtl/pingpong_bank_arbiter.sv
// Ping-pong IFM bank arbiter: two banks alternate between a word-serial producer and a consumer.
// Optional build macro PPB_FLUSH_EN adds an early-close flush input and a per-bank word count output.
module pingpong_bank_arbiter #(
  parameter int unsigned BANK_WORDS = 100,
  parameter int unsigned ADDR_WIDTH = $clog2(BANK_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prod_wr_en,
`ifdef PPB_FLUSH_EN
  input  logic                  prod_flush,
  output logic [ADDR_WIDTH:0]   cons_words,
`endif
  output logic                  prod_ready,
  output logic                  prod_bank,
  output logic [ADDR_WIDTH-1:0] prod_wr_addr,
  output logic                  cons_start,
  output logic                  cons_bank,
  input  logic                  cons_end,
  output logic [1:0]            bank_full,
  output logic                  overflow_err
);

  localparam logic [1:0] B_EMPTY    = 2'd0;
  localparam logic [1:0] B_FILLING  = 2'd1;
  localparam logic [1:0] B_FULL     = 2'd2;
  localparam logic [1:0] B_DRAINING = 2'd3;

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_START = 2'd1;
  localparam logic [1:0] C_BUSY  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BANK_WORDS - 1);

  logic [1:0]            bank_q [2];
  logic [1:0]            bank_d [2];
  logic                  wp_q, wp_d;
  logic                  rp_q, rp_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            cs_q, cs_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_accept;
  logic                  close_bank;
`ifdef PPB_FLUSH_EN
  logic [ADDR_WIDTH:0]   words_q [2];
  logic [ADDR_WIDTH:0]   words_d [2];
  logic                  flush_go;
`endif

  assign prod_ready   = (bank_q[wp_q] == B_EMPTY) || (bank_q[wp_q] == B_FILLING);
  assign prod_bank    = wp_q;
  assign prod_wr_addr = addr_q;
  assign cons_start   = (cs_q == C_START);
  assign cons_bank    = rp_q;
  // FULL and DRAINING are the only encodings with the upper bit set
  assign bank_full    = {bank_q[1][1], bank_q[0][1]};
  assign overflow_err = ovf_q;
`ifdef PPB_FLUSH_EN
  assign cons_words   = words_q[rp_q];
`endif

  always_comb begin
    bank_d     = bank_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    addr_d     = addr_q;
    cs_d       = cs_q;
    ovf_d      = ovf_q;
    wr_accept  = prod_wr_en && prod_ready;
    close_bank = wr_accept && (addr_q == LAST_ADDR);
`ifdef PPB_FLUSH_EN
    words_d    = words_q;
    flush_go   = prod_flush && (wr_accept || (bank_q[wp_q] == B_FILLING));
    close_bank = close_bank || flush_go;
`endif

    if (prod_wr_en && !prod_ready)
      ovf_d = 1'b1;

    if (wr_accept) begin
      bank_d[wp_q] = B_FILLING;
      addr_d       = addr_q + 1'b1;
    end

    if (close_bank) begin
      bank_d[wp_q] = B_FULL;
      addr_d       = '0;
      wp_d         = ~wp_q;
`ifdef PPB_FLUSH_EN
      words_d[wp_q] = {1'b0, addr_q} + {{ADDR_WIDTH{1'b0}}, wr_accept};
`endif
    end

    // Consumer only touches bank[rp], which is never the bank the producer holds open
    case (cs_q)
      C_IDLE: begin
        if (bank_q[rp_q] == B_FULL)
          cs_d = C_START;
      end
      C_START: begin
        cs_d         = C_BUSY;
        bank_d[rp_q] = B_DRAINING;
      end
      C_BUSY: begin
        if (cons_end) begin
          cs_d         = C_IDLE;
          bank_d[rp_q] = B_EMPTY;
          rp_d         = ~rp_q;
        end
      end
      default: cs_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q  <= '{B_EMPTY, B_EMPTY};
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      addr_q  <= '0;
      cs_q    <= C_IDLE;
      ovf_q   <= 1'b0;
`ifdef PPB_FLUSH_EN
      words_q <= '{default: '0};
`endif
    end else begin
      bank_q  <= bank_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      ovf_q   <= ovf_d;
`ifdef PPB_FLUSH_EN
      words_q <= words_d;
`endif
    end
  end

endmodule

// File: tb/tb_pingpong_bank_arbiter.sv
// Self-checking bench for pingpong_bank_arbiter: directed table, corner sequences, and
// randomized traffic against a bank-occupancy model.
module tb_pingpong_bank_arbiter;

  localparam int unsigned BW = 100;
  localparam int unsigned AW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          prod_wr_en;
  logic          prod_ready;
  logic          prod_bank;
  logic [AW-1:0] prod_wr_addr;
  logic          cons_start;
  logic          cons_bank;
  logic          cons_end;
  logic [1:0]    bank_full;
  logic          overflow_err;
`ifdef PPB_FLUSH_EN
  logic          prod_flush;
  logic [AW:0]   cons_words;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  pingpong_bank_arbiter #(.BANK_WORDS(BW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .prod_wr_en   (prod_wr_en),
`ifdef PPB_FLUSH_EN
    .prod_flush   (prod_flush),
    .cons_words   (cons_words),
`endif
    .prod_ready   (prod_ready),
    .prod_bank    (prod_bank),
    .prod_wr_addr (prod_wr_addr),
    .cons_start   (cons_start),
    .cons_bank    (cons_bank),
    .cons_end     (cons_end),
    .bank_full    (bank_full),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  // Model: words in the open bank, which banks are closed (full/draining) and since when,
  // and whether the consumer currently owns a bank. Start fires two cycles after both the
  // bank has closed and the consumer has released the previous one.
  int m_fill, m_wp, m_rp, m_start, m_free;
  bit m_busy, m_ovf;
  bit m_closed [2];
  int m_close  [2];
  int m_words  [2];

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit m_cs();
    return !m_busy && m_closed[m_rp] && (cyc == imax(m_close[m_rp], m_free) + 2);
  endfunction

  task automatic model_reset();
    m_fill = 0; m_wp = 0; m_rp = 0; m_busy = 0; m_ovf = 0;
    m_start = -100; m_free = -100;
    m_closed = '{0, 0};
    m_close  = '{-100, -100};
    m_words  = '{0, 0};
  endtask

  task automatic model_edge(input bit we, input bit ce, input bit fl);
    bit start_now, ce_eff, accept;
    start_now = m_cs();
    ce_eff    = m_busy && ce && (cyc > m_start);
    accept    = we && !m_closed[m_wp];
    if (we && !accept) m_ovf = 1;
    if (accept) m_fill++;
    if ((m_fill == BW) || (fl && m_fill > 0)) begin
      m_closed[m_wp] = 1;
      m_close[m_wp]  = cyc;
      m_words[m_wp]  = m_fill;
      m_fill         = 0;
      m_wp           = 1 - m_wp;
    end
    if (ce_eff) begin
      m_closed[m_rp] = 0;
      m_busy         = 0;
      m_free         = cyc;
      m_rp           = 1 - m_rp;
    end
    if (start_now) begin
      m_busy  = 1;
      m_start = cyc;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit we, input bit ce, input bit fl);
    prod_wr_en = we;
    cons_end   = ce;
`ifdef PPB_FLUSH_EN
    prod_flush = fl;
`endif
    @(posedge clk);
    model_edge(we, ce, fl);
    cyc++;
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".prod_ready"},   int'(prod_ready),   int'(!m_closed[m_wp]));
    chk({tag, ".prod_bank"},    int'(prod_bank),    m_wp);
    chk({tag, ".prod_wr_addr"}, int'(prod_wr_addr), m_fill);
    chk({tag, ".cons_start"},   int'(cons_start),   int'(m_cs()));
    chk({tag, ".cons_bank"},    int'(cons_bank),    m_rp);
    chk({tag, ".bank_full"},    int'(bank_full),    int'({m_closed[1], m_closed[0]}));
    chk({tag, ".overflow_err"}, int'(overflow_err), int'(m_ovf));
`ifdef PPB_FLUSH_EN
    if (m_closed[m_rp])
      chk({tag, ".cons_words"}, int'(cons_words), m_words[m_rp]);
`endif
  endtask

  // Reset is raised mid-cycle so its effect is seen before any clock edge.
  task automatic reset_chk(input string tag);
    reset      = 1'b1;
    prod_wr_en = 1'b0;
    cons_end   = 1'b0;
`ifdef PPB_FLUSH_EN
    prod_flush = 1'b0;
`endif
    #1;
    chk({tag, ".rst.prod_ready"},   int'(prod_ready),   1);
    chk({tag, ".rst.prod_bank"},    int'(prod_bank),    0);
    chk({tag, ".rst.prod_wr_addr"}, int'(prod_wr_addr), 0);
    chk({tag, ".rst.cons_start"},   int'(cons_start),   0);
    chk({tag, ".rst.cons_bank"},    int'(cons_bank),    0);
    chk({tag, ".rst.bank_full"},    int'(bank_full),    0);
    chk({tag, ".rst.overflow_err"}, int'(overflow_err), 0);
    model_reset();
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    int n; bit we; bit ce;
    int bf; int pb; int addr; int rdy; int cs; int cb; int ovf;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{0,   0, 0, 0, 0, 0,  1, 0, 0, 0};
    tbl[1] = '{99,  1, 0, 0, 0, 99, 1, 0, 0, 0};
    tbl[2] = '{1,   1, 0, 1, 1, 0,  1, 0, 0, 0};
    tbl[3] = '{1,   0, 0, 1, 1, 0,  1, 1, 0, 0};
    tbl[4] = '{1,   0, 0, 1, 1, 0,  1, 0, 0, 0};
    tbl[5] = '{100, 1, 0, 3, 0, 0,  0, 0, 0, 0};
    tbl[6] = '{1,   1, 0, 3, 0, 0,  0, 0, 0, 1};
    tbl[7] = '{1,   0, 1, 2, 0, 0,  1, 0, 1, 1};
    tbl[8] = '{1,   0, 0, 2, 0, 0,  1, 1, 1, 1};
    tbl[9] = '{1,   0, 0, 2, 0, 0,  1, 0, 1, 1};

    reset      = 1'b1;
    prod_wr_en = 1'b0;
    cons_end   = 1'b0;
`ifdef PPB_FLUSH_EN
    prod_flush = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      repeat (tbl[i].n) step(tbl[i].we, tbl[i].ce, 1'b0);
      chk($sformatf("row%0d.bank_full", i),    int'(bank_full),    tbl[i].bf);
      chk($sformatf("row%0d.prod_bank", i),    int'(prod_bank),    tbl[i].pb);
      chk($sformatf("row%0d.prod_wr_addr", i), int'(prod_wr_addr), tbl[i].addr);
      chk($sformatf("row%0d.prod_ready", i),   int'(prod_ready),   tbl[i].rdy);
      chk($sformatf("row%0d.cons_start", i),   int'(cons_start),   tbl[i].cs);
      chk($sformatf("row%0d.cons_bank", i),    int'(cons_bank),    tbl[i].cb);
      chk($sformatf("row%0d.overflow_err", i), int'(overflow_err), tbl[i].ovf);
    end

    // Last write to bank 1 coincides with cons_end on draining bank 0
    reset_chk("sim");
    repeat (100) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("sim.cs_bank0", int'(cons_start), 1);
    step(1'b0, 1'b0, 1'b0);
    repeat (99) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("sim.bank_full",  int'(bank_full),    2);
    chk("sim.cons_bank",  int'(cons_bank),    1);
    chk("sim.prod_bank",  int'(prod_bank),    0);
    chk("sim.prod_ready", int'(prod_ready),   1);
    chk("sim.addr",       int'(prod_wr_addr), 0);
    chk("sim.cs_k1",      int'(cons_start),   0);
    step(1'b0, 1'b0, 1'b0);
    chk("sim.cs_k2",      int'(cons_start),   1);
    chk("sim.cs_bank1",   int'(cons_bank),    1);

    // Reset mid-fill, then reset mid-drain; neither may leave a pending start behind
    reset_chk("rf0");
    repeat (50) step(1'b1, 1'b0, 1'b0);
    chk("rf.addr50", int'(prod_wr_addr), 50);
    reset_chk("rf1");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("rf.idle%0d.cs", i), int'(cons_start), 0);
    end
    repeat (100) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("rd.cs", int'(cons_start), 1);
    step(1'b0, 1'b0, 1'b0);
    reset_chk("rd");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("rd.idle%0d.cs", i), int'(cons_start), 0);
      chk($sformatf("rd.idle%0d.bf", i), int'(bank_full), 0);
    end

    // cons_end while idle, and during the start cycle, is ignored
    step(1'b0, 1'b1, 1'b0);
    chk("ci.bank_full", int'(bank_full),  0);
    chk("ci.cons_bank", int'(cons_bank),  0);
    chk("ci.ready",     int'(prod_ready), 1);
    repeat (100) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("cs.start", int'(cons_start), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("cs.bank_full", int'(bank_full), 1);
    chk("cs.cons_bank", int'(cons_bank), 0);
    step(1'b0, 1'b1, 1'b0);
    chk("cb.bank_full", int'(bank_full), 0);
    chk("cb.cons_bank", int'(cons_bank), 1);

`ifdef PPB_FLUSH_EN
    reset_chk("fl");
    repeat (37) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("fl.prod_bank", int'(prod_bank),    1);
    chk("fl.bank_full", int'(bank_full),    1);
    chk("fl.addr",      int'(prod_wr_addr), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("fl.cs",        int'(cons_start),   1);
    chk("fl.words37",   int'(cons_words),   37);
    chk("fl.cons_bank", int'(cons_bank),    0);
    step(1'b0, 1'b0, 1'b1);
    chk("fl.empty_bf",  int'(bank_full),    1);
    chk("fl.empty_pb",  int'(prod_bank),    1);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("fl.wr_bf",     int'(bank_full),    3);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("fl.cs1",       int'(cons_start),   1);
    chk("fl.words5",    int'(cons_words),   5);
`endif

    // Randomized traffic with varied producer pressure and consumer speed
    for (int ph = 0; ph < 3; ph++) begin
      int unsigned we_pct, ce_pct;
      reset_chk($sformatf("rnd%0d", ph));
      we_pct = (ph == 0) ? 90 : (ph == 1) ? 60 : 98;
      ce_pct = (ph == 0) ? 2  : (ph == 1) ? 25 : 12;
      for (int i = 0; i < 1500; i++) begin
        bit we, ce, fl;
        we = ($urandom_range(0, 99) < we_pct);
        ce = ($urandom_range(0, 99) < ce_pct);
        fl = 1'b0;
`ifdef PPB_FLUSH_EN
        fl = ($urandom_range(0, 99) < 3);
`endif
        step(we, ce, fl);
        chk_model($sformatf("rnd%0d", ph));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
